// File: rtl/gps_ack_peak_search_if.sv
// Result-record stream from the acquisition peak search to the acquisition controller.
// One record per satellite lane; fields are held stable while valid && !ready.
interface gps_ack_peak_search_if #(
  parameter int M_W = 11
);
  logic           res_valid;
  logic           res_ready;
  logic [5:0]     res_sat;
  logic [9:0]     res_phase;
  logic [M_W-1:0] res_peak;
  logic           res_detected;

  modport master (
    output res_valid, res_sat, res_phase, res_peak, res_detected,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_sat, res_phase, res_peak, res_detected,
    output res_ready
  );
endinterface

// File: rtl/gps_ack_peak_search.sv
// Per-lane peak / second-peak tracker over a 1023-chip code-phase sweep for four
// satellites, with a detect decision and a four-record result stream per sweep.
module gps_ack_peak_search #(
  parameter int INT_W      = 12,
  parameter int MID        = 2048,
  parameter int MARGIN     = 64,
  parameter int LAST_PHASE = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             corr_complete,
  input  logic [9:0]       code_phase,
  input  logic [5:0]       sat0,
  input  logic [5:0]       sat1,
  input  logic [5:0]       sat2,
  input  logic [5:0]       sat3,
  input  logic [INT_W-1:0] integrator_0,
  input  logic [INT_W-1:0] integrator_1,
  input  logic [INT_W-1:0] integrator_2,
  input  logic [INT_W-1:0] integrator_3,
  input  logic [INT_W-2:0] threshold,
  gps_ack_peak_search_if.master res,
  output logic             sweep_done,
  output logic             overrun
);

  localparam int               M_W      = INT_W - 1;
  localparam logic [INT_W-1:0] MID_V    = INT_W'(MID);
  localparam logic [9:0]       LAST_V   = 10'(LAST_PHASE);
  localparam logic [M_W-1:0]   MARGIN_V = M_W'(MARGIN);

  typedef logic [M_W-1:0] metric_t;

  typedef struct packed {
    logic [5:0] sat;
    logic [9:0] phase;
    metric_t    peak;
    logic       detected;
  } rec_t;

  typedef enum logic [1:0] {ACCUM, EVAL, EMIT} state_t;

  state_t           state;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic             cc_q;
  logic             valid_q;
  rec_t             out_q;

  metric_t          peak     [4];
  metric_t          second   [4];
  logic [9:0]       peak_ph  [4];
  logic [5:0]       sat_q    [4];
  rec_t             bank     [4];

  logic [INT_W-1:0] integ    [4];
  logic [INT_W-1:0] diff     [4];
  logic [5:0]       sat_in   [4];
  metric_t          m        [4];
  rec_t             eval_rec [4];

  logic             capture;
  logic             first;
  logic             last;

  assign integ[0]  = integrator_0;
  assign integ[1]  = integrator_1;
  assign integ[2]  = integrator_2;
  assign integ[3]  = integrator_3;
  assign sat_in[0] = sat0;
  assign sat_in[1] = sat1;
  assign sat_in[2] = sat2;
  assign sat_in[3] = sat3;

  assign capture = corr_complete & ~cc_q;
  assign first   = capture && (code_phase == 10'd0);
  assign last    = capture && (code_phase == LAST_V);
  assign idx_nxt = idx + 2'd1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      diff[i] = (integ[i] >= MID_V) ? (integ[i] - MID_V) : (MID_V - integ[i]);
      // Only an all-zero integrator reaches MID itself; pin it to full scale
      // rather than letting it wrap to zero.
      m[i] = diff[i][INT_W-1] ? '1 : diff[i][M_W-1:0];

      eval_rec[i].sat      = sat_q[i];
      eval_rec[i].phase    = peak_ph[i];
      eval_rec[i].peak     = peak[i];
      eval_rec[i].detected = (peak[i] >= threshold) &&
                             ((peak[i] - second[i]) >= MARGIN_V);
    end
  end

  // Lane trackers run in every state; the output bank is what isolates a
  // finished sweep from the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cc_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        peak[i]    <= '0;
        second[i]  <= '0;
        peak_ph[i] <= '0;
      end
    end else if (clear) begin
      cc_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        peak[i]    <= '0;
        second[i]  <= '0;
        peak_ph[i] <= '0;
      end
    end else begin
      cc_q <= corr_complete;
      if (capture) begin
        for (int i = 0; i < 4; i++) begin
          if (first) begin
            peak[i]    <= m[i];
            second[i]  <= '0;
            peak_ph[i] <= '0;
          end else if (m[i] > peak[i]) begin
            // NOTE: second takes the pre-edge peak because both are
            // non-blocking; a blocking peak update here would copy the new value.
            second[i]  <= peak[i];
            peak[i]    <= m[i];
            peak_ph[i] <= code_phase;
          end else if (m[i] > second[i]) begin
            second[i]  <= m[i];
          end
        end
      end
    end
  end

  // NOTE: sat_q and bank carry no reset: sat_q is written by the closing
  // capture and bank in EVAL, both before anything reads them.
  always_ff @(posedge clk) begin
    if (last) begin
      for (int i = 0; i < 4; i++) sat_q[i] <= sat_in[i];
    end
    if (state == EVAL) begin
      for (int i = 0; i < 4; i++) bank[i] <= eval_rec[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACCUM;
      idx        <= '0;
      valid_q    <= 1'b0;
      out_q      <= '0;
      sweep_done <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      state      <= ACCUM;
      idx        <= '0;
      valid_q    <= 1'b0;
      out_q      <= '0;
      sweep_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (last && (state == EMIT)) overrun <= 1'b1;

      unique case (state)
        ACCUM: begin
          if (last) state <= EVAL;
        end
        EVAL: begin
          out_q      <= eval_rec[0];
          valid_q    <= 1'b1;
          sweep_done <= 1'b1;
          idx        <= '0;
          state      <= EMIT;
        end
        EMIT: begin
          if (res.res_ready) begin
            if (idx == 2'd3) begin
              valid_q <= 1'b0;
              out_q   <= '0;
              idx     <= '0;
              state   <= ACCUM;
            end else begin
              idx   <= idx_nxt;
              out_q <= bank[idx_nxt];
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign res.res_valid    = valid_q;
  assign res.res_sat      = out_q.sat;
  assign res.res_phase    = out_q.phase;
  assign res.res_peak     = out_q.peak;
  assign res.res_detected = out_q.detected;

endmodule

// File: tb/tb_gps_ack_peak_search.sv
// Directed bench for gps_ack_peak_search: full 1024-phase sweeps with hand-computed
// peak records, stall, edge-detect, overrun/clear and mid-emission reset scenarios.
module tb_gps_ack_peak_search;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        corr_complete;
  logic [9:0]  code_phase;
  logic [5:0]  sat0, sat1, sat2, sat3;
  logic [11:0] integrator_0, integrator_1, integrator_2, integrator_3;
  logic [10:0] threshold;
  logic        sweep_done;
  logic        overrun;

  gps_ack_peak_search_if res_if();

  gps_ack_peak_search dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .corr_complete (corr_complete),
    .code_phase    (code_phase),
    .sat0          (sat0),
    .sat1          (sat1),
    .sat2          (sat2),
    .sat3          (sat3),
    .integrator_0  (integrator_0),
    .integrator_1  (integrator_1),
    .integrator_2  (integrator_2),
    .integrator_3  (integrator_3),
    .threshold     (threshold),
    .res           (res_if),
    .sweep_done    (sweep_done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [27:0] got   [4];
  logic [27:0] exp_r [4];
  int          n_got;

  function automatic logic [27:0] rec(input logic [5:0] s, input int p, input int pk, input logic d);
    return {s, 10'(p), 11'(pk), d};
  endfunction

  function automatic logic [27:0] obs();
    return {res_if.res_sat, res_if.res_phase, res_if.res_peak, res_if.res_detected};
  endfunction

  function automatic logic [30:0] all_outs();
    return {res_if.res_valid, obs(), sweep_done, overrun};
  endfunction

  // Integrator value per scenario, lane and code phase; 2048 is the uncorrelated mean.
  function automatic logic [11:0] integ_val(input int scn, input int lane, input int ph);
    logic [11:0] v;
    v = 12'd2048;
    case (scn)
      0: begin
        if (lane == 0 && ph == 10)  v = 12'd1000;
        if (lane == 0 && ph == 900) v = 12'd3100;
        if (lane == 1 && ph == 5)   v = 12'd2748;
        if (lane == 1 && ph == 600) v = 12'd1348;
        if (lane == 2 && ph == 517) v = 12'd3000;
        if (lane == 3 && ph == 300) v = 12'd2100;
      end
      1: begin
        if (lane == 0 && ph == 20)  v = 12'd2648;
        if (lane == 0 && ph == 40)  v = 12'd1512;
        if (lane == 1 && ph == 100) v = 12'd2648;
        if (lane == 1 && ph == 200) v = 12'd2585;
        if (lane == 2 && ph == 300) v = 12'd2647;
        if (lane == 3 && ph == 0)   v = 12'd2548;
      end
      2: if (lane == 1 && ph == 7)  v = 12'd2148;
      3: if (lane == 0 && ph == 50) v = 12'd2248;
      4: if (lane == 1 && ph == 8)  v = 12'd3500;
      default: v = 12'd2048;
    endcase
    return v;
  endfunction

  // One correlator result; while held high past the capture edge the integrators
  // jump to a large value that must not be picked up.
  task automatic pulse(input int scn, input int ph, input int hold);
    @(posedge clk); #1;
    code_phase    = 10'(ph);
    integrator_0  = integ_val(scn, 0, ph);
    integrator_1  = integ_val(scn, 1, ph);
    integrator_2  = integ_val(scn, 2, ph);
    integrator_3  = integ_val(scn, 3, ph);
    corr_complete = 1'b1;
    @(posedge clk); #1;
    if (hold > 1) begin
      integrator_0 = 12'd2900;
      integrator_1 = 12'd2900;
      integrator_2 = 12'd2900;
      integrator_3 = 12'd2900;
      repeat (hold - 1) @(posedge clk);
      #1;
    end
    corr_complete = 1'b0;
  endtask

  task automatic drive_sweep(input int scn, input int first_ph, input int last_ph);
    for (int ph = first_ph; ph <= last_ph; ph++)
      pulse(scn, ph, (scn == 0 && ph == 300) ? 10 : 1);
  endtask

  task automatic collect(input int budget, input int want);
    n_got = 0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    for (int c = 0; c < budget; c++) begin
      if (res_if.res_valid && res_if.res_ready) begin
        got[n_got] = obs();
        n_got++;
      end
      if (n_got == want) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; clear = 1'b0; corr_complete = 1'b0; code_phase = '0;
    integrator_0 = 12'd2048; integrator_1 = 12'd2048;
    integrator_2 = 12'd2048; integrator_3 = 12'd2048;
    sat0 = '0; sat1 = '0; sat2 = '0; sat3 = '0;
    threshold = '0; res_if.res_ready = 1'b0;
    #12;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h, expected 0", all_outs());
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++; $display("FAIL idle_after_reset: got %h, expected 0", all_outs());
    end
  endtask

  task automatic test_main_sweep();
    threshold = 11'd400;
    sat0 = 6'd3; sat1 = 6'd17; sat2 = 6'd22; sat3 = 6'd31;
    res_if.res_ready = 1'b1;
    drive_sweep(0, 0, 1023);
    sat0 = 6'd60; sat1 = 6'd61; sat2 = 6'd62; sat3 = 6'd63;
    @(negedge clk);
    n_cmp++;
    if ({sweep_done, res_if.res_valid} !== 2'b00) begin
      n_err++; $display("FAIL eval_cycle: got done/valid %b, expected 00", {sweep_done, res_if.res_valid});
    end
    @(negedge clk);
    n_cmp++;
    if ({sweep_done, res_if.res_valid} !== 2'b11) begin
      n_err++; $display("FAIL sweep_latency: got done/valid %b, expected 11", {sweep_done, res_if.res_valid});
    end
    collect(20, 4);
    exp_r[0] = rec(6'd3,  900, 1052, 1'b0);
    exp_r[1] = rec(6'd17, 5,   700,  1'b0);
    exp_r[2] = rec(6'd22, 517, 952,  1'b1);
    exp_r[3] = rec(6'd31, 300, 52,   1'b0);
    n_cmp++;
    if (n_got !== 4) begin
      n_err++; $display("FAIL main_handshakes: got %0d, expected 4", n_got);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== exp_r[i]) begin
        n_err++; $display("FAIL main_rec%0d: got %h, expected %h", i, got[i], exp_r[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({res_if.res_valid, sweep_done} !== 2'b00) begin
      n_err++; $display("FAIL valid_drop: got valid/done %b, expected 00", {res_if.res_valid, sweep_done});
    end
  endtask

  task automatic test_stall_boundary();
    logic [27:0] held;
    logic        stable;
    int          extra;
    threshold = 11'd600;
    sat0 = 6'd3; sat1 = 6'd17; sat2 = 6'd22; sat3 = 6'd31;
    res_if.res_ready = 1'b0;
    drive_sweep(1, 0, 1023);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({sweep_done, res_if.res_valid} !== 2'b11) begin
      n_err++; $display("FAIL stall_start: got done/valid %b, expected 11", {sweep_done, res_if.res_valid});
    end
    held   = obs();
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!res_if.res_valid || obs() !== held) stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_err++; $display("FAIL stall_stable: got %b, expected 1", stable);
    end
    @(posedge clk); #1 res_if.res_ready = 1'b1;
    @(negedge clk);
    collect(20, 4);
    exp_r[0] = rec(6'd3,  20,  600, 1'b1);
    exp_r[1] = rec(6'd17, 100, 600, 1'b0);
    exp_r[2] = rec(6'd22, 300, 599, 1'b0);
    exp_r[3] = rec(6'd31, 0,   500, 1'b0);
    n_cmp++;
    if (n_got !== 4) begin
      n_err++; $display("FAIL stall_handshakes: got %0d, expected 4", n_got);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== exp_r[i]) begin
        n_err++; $display("FAIL boundary_rec%0d: got %h, expected %h", i, got[i], exp_r[i]);
      end
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_if.res_valid && res_if.res_ready) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_err++; $display("FAIL extra_handshakes: got %0d, expected 0", extra);
    end
  endtask

  task automatic test_overrun_clear();
    logic ok_idle;
    threshold = 11'd50;
    sat0 = 6'd3; sat1 = 6'd17; sat2 = 6'd22; sat3 = 6'd31;
    res_if.res_ready = 1'b1;
    drive_sweep(4, 0, 30);
    res_if.res_ready = 1'b0;
    drive_sweep(2, 0, 1023);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({sweep_done, res_if.res_valid, overrun} !== 3'b110) begin
      n_err++; $display("FAIL sweep_a_pending: got done/valid/ovr %b, expected 110",
                        {sweep_done, res_if.res_valid, overrun});
    end
    sat0 = 6'd40; sat1 = 6'd41; sat2 = 6'd42; sat3 = 6'd43;
    drive_sweep(3, 0, 1023);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({res_if.res_valid, overrun} !== 2'b11) begin
      n_err++; $display("FAIL overrun_set: got valid/ovr %b, expected 11", {res_if.res_valid, overrun});
    end
    n_cmp++;
    if (obs() !== rec(6'd3, 0, 0, 1'b0)) begin
      n_err++; $display("FAIL pending_rec0: got %h, expected %h", obs(), rec(6'd3, 0, 0, 1'b0));
    end
    @(posedge clk); #1 res_if.res_ready = 1'b1;
    @(negedge clk);
    collect(10, 2);
    @(posedge clk); #1 res_if.res_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (n_got !== 2) begin
      n_err++; $display("FAIL overrun_handshakes: got %0d, expected 2", n_got);
    end
    n_cmp++;
    if (got[1] !== rec(6'd17, 7, 100, 1'b1)) begin
      n_err++; $display("FAIL sweep_a_rec1: got %h, expected %h", got[1], rec(6'd17, 7, 100, 1'b1));
    end
    n_cmp++;
    if ({res_if.res_valid, overrun, obs()} !== {2'b11, rec(6'd22, 0, 0, 1'b0)}) begin
      n_err++; $display("FAIL bank_isolated: got %h, expected %h",
                        {res_if.res_valid, overrun, obs()}, {2'b11, rec(6'd22, 0, 0, 1'b0)});
    end
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++; $display("FAIL clear_outputs: got %h, expected 0", all_outs());
    end
    ok_idle = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (res_if.res_valid || overrun) ok_idle = 1'b0;
    end
    n_cmp++;
    if (ok_idle !== 1'b1) begin
      n_err++; $display("FAIL idle_after_clear: got %b, expected 1", ok_idle);
    end
  endtask

  task automatic test_reset_mid_emit();
    threshold = 11'd150;
    sat0 = 6'd9; sat1 = 6'd10; sat2 = 6'd11; sat3 = 6'd12;
    res_if.res_ready = 1'b0;
    drive_sweep(3, 0, 1023);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({res_if.res_valid, obs()} !== {1'b1, rec(6'd9, 50, 200, 1'b1)}) begin
      n_err++; $display("FAIL pre_reset_rec0: got %h, expected %h",
                        {res_if.res_valid, obs()}, {1'b1, rec(6'd9, 50, 200, 1'b1)});
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++; $display("FAIL async_reset_outputs: got %h, expected 0", all_outs());
    end
    @(posedge clk); #1 rst = 1'b1;
    res_if.res_ready = 1'b1;
    threshold = 11'd50;
    sat0 = 6'd5; sat1 = 6'd6; sat2 = 6'd7; sat3 = 6'd8;
    @(negedge clk);
    n_cmp++;
    if (res_if.res_valid !== 1'b0) begin
      n_err++; $display("FAIL valid_after_reset: got %b, expected 0", res_if.res_valid);
    end
    drive_sweep(2, 0, 1023);
    repeat (2) @(negedge clk);
    collect(20, 4);
    exp_r[0] = rec(6'd5, 0, 0,   1'b0);
    exp_r[1] = rec(6'd6, 7, 100, 1'b1);
    exp_r[2] = rec(6'd7, 0, 0,   1'b0);
    exp_r[3] = rec(6'd8, 0, 0,   1'b0);
    n_cmp++;
    if (n_got !== 4) begin
      n_err++; $display("FAIL recovery_handshakes: got %0d, expected 4", n_got);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== exp_r[i]) begin
        n_err++; $display("FAIL recovery_rec%0d: got %h, expected %h", i, got[i], exp_r[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_main_sweep();
    test_stall_boundary();
    test_overrun_clear();
    test_reset_mid_emit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
